// File: rtl/mult_unit_if.sv
// mult_unit_if: request/result bundle between a multiply issuer and mult_unit.
// master drives the request side, slave (the multiplier) drives the result side.
interface mult_unit_if #(
  parameter int N = 32
);
  logic         start;
  logic         is_signed;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add multiplier for MULT/MULTU, 2N-bit
// product delivered as hi/lo. A single N-bit adder is time-shared between the
// partial-product accumulation and the final two's-complement negation.
// Build option: define MULT_EARLY_EXIT_EN to leave CALC as soon as the
// remaining multiplier bits are all zero (results are identical either way).
//
// state  | meaning
// IDLE   | waiting for start; hi/lo hold the last result
// CALC   | one shift-add step per clock on {p_hi,p_lo}
// NEG_LO | negate low half (~p_lo + 1), keep the carry
// NEG_HI | negate high half (~p_hi + carry), publish result
module mult_unit #(
  parameter int N = 32
) (
  input logic       clk,
  input logic       rst_n,
  mult_unit_if.slave mif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, NEG_LO, NEG_HI} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  mcand, mcand_nxt;
  logic [N-1:0]  p_hi, p_hi_nxt;
  logic [N-1:0]  p_lo, p_lo_nxt;
  logic [N-1:0]  hi_q, hi_nxt;
  logic [N-1:0]  lo_q, lo_nxt;
  logic          neg, neg_nxt;
  logic          cy, cy_nxt;
  logic          done_q, done_nxt;
  logic [CW-1:0] iter_left, iter_nxt;

  logic [N-1:0]  add_a, add_b, add_sum;
  logic          add_cin, add_c;
  logic [N-1:0]  abs_a, abs_b;
  logic          early_exit;
  logic          last_step;

  // Magnitudes of the operands; the most-negative value maps to 2^(N-1),
  // which still fits unsigned in N bits.
  assign abs_a = (mif.is_signed && mif.a[N-1]) ? (~mif.a + N'(1)) : mif.a;
  assign abs_b = (mif.is_signed && mif.b[N-1]) ? (~mif.b + N'(1)) : mif.b;

  // Shared ripple adder; only sum and carry-out are consumed.
  assign {add_c, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

`ifdef MULT_EARLY_EXIT_EN
  // Low iter_left bits of p_lo are the multiplier bits not yet consumed.
  logic [N-1:0] rem_mask;
  assign rem_mask   = ~({N{1'b1}} << iter_left);
  assign early_exit = ((p_lo & rem_mask) == '0);
`else
  assign early_exit = 1'b0;
`endif

  assign last_step = (iter_left == CW'(1)) || early_exit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, adder input muxing and datapath next values.
  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    p_hi_nxt  = p_hi;
    p_lo_nxt  = p_lo;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    neg_nxt   = neg;
    cy_nxt    = cy;
    iter_nxt  = iter_left;
    done_nxt  = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;

    case (state)
      IDLE: begin
        if (mif.start) begin
          mcand_nxt = abs_a;
          p_hi_nxt  = '0;
          p_lo_nxt  = abs_b;
          neg_nxt   = mif.is_signed & (mif.a[N-1] ^ mif.b[N-1]);
          iter_nxt  = CW'(N);
          state_nxt = CALC;
        end
      end

      CALC: begin
        add_a = p_hi;
        add_b = p_lo[0] ? mcand : '0;
        if (early_exit) begin
          // Remaining steps would all add zero: do the whole shift at once.
          {p_hi_nxt, p_lo_nxt} = {p_hi, p_lo} >> iter_left;
        end else begin
          {p_hi_nxt, p_lo_nxt} = {add_c, add_sum, p_lo[N-1:1]};
        end
        iter_nxt = iter_left - CW'(1);
        if (last_step) begin
          iter_nxt = '0;
          if (neg) begin
            state_nxt = NEG_LO;
          end else begin
            hi_nxt    = p_hi_nxt;
            lo_nxt    = p_lo_nxt;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      NEG_LO: begin
        add_a     = ~p_lo;
        add_cin   = 1'b1;
        p_lo_nxt  = add_sum;
        cy_nxt    = add_c;
        state_nxt = NEG_HI;
      end

      NEG_HI: begin
        // hi and lo are published together so they never show a half result.
        add_a     = ~p_hi;
        add_cin   = cy;
        hi_nxt    = add_sum;
        lo_nxt    = p_lo;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg       <= 1'b0;
      cy        <= 1'b0;
      iter_left <= '0;
      done_q    <= 1'b0;
    end else begin
      mcand     <= mcand_nxt;
      p_hi      <= p_hi_nxt;
      p_lo      <= p_lo_nxt;
      hi_q      <= hi_nxt;
      lo_q      <= lo_nxt;
      neg       <= neg_nxt;
      cy        <= cy_nxt;
      iter_left <= iter_nxt;
      done_q    <= done_nxt;
    end
  end

  assign mif.busy = (state != IDLE);
  assign mif.done = done_q;
  assign mif.hi   = hi_q;
  assign mif.lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed vectors with literal expectations, plus a cycle-level
// reference model compared against busy/done/hi/lo on every falling edge.
module tb_mult_unit;

  localparam int N = 32;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   cmp_en;

  mult_unit_if #(.N(N)) mif();

  mult_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_busy;
  bit          m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;

  function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b, logic s);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic int ref_lat(logic [31:0] a, logic [31:0] b, logic s);
    int calc;
    bit neg;
    logic [31:0] mp;
    neg  = s && (a[31] != b[31]);
    mp   = (s && b[31]) ? (32'd0 - b) : b;
    calc = N;
`ifdef MULT_EARLY_EXIT_EN
    begin
      int m;
      m = -1;
      for (int i = 0; i < N; i++) if (mp[i]) m = i;
      calc = (m + 2 < N) ? m + 2 : N;
    end
`endif
    if (mp == 32'hDEAD_BEEF) calc = calc; // keeps mp referenced in every build
    return calc + (neg ? 2 : 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          {m_hi, m_lo} = m_pend;
        end
      end else if (mif.start) begin
        m_pend = ref_prod(mif.a, mif.b, mif.is_signed);
        m_left = ref_lat(mif.a, mif.b, mif.is_signed);
        m_busy = 1;
      end
    end
  end

  // Compare process: DUT outputs against the model every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      tests++;
      if (mif.busy !== m_busy || mif.done !== m_done || mif.hi !== m_hi || mif.lo !== m_lo) begin
        fails++;
        $display("FAIL model_cmp t=%0t: dut busy=%b done=%b hi=%h lo=%h, model busy=%b done=%b hi=%h lo=%h",
                 $time, mif.busy, mif.done, mif.hi, mif.lo, m_busy, m_done, m_hi, m_lo);
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts rising edges after the current one until done is seen (#1 after edge).
  task automatic wait_done(string name, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!mif.done && cyc < 200);
    if (!mif.done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done after %0d cycles, required within 200", name, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat_def;
    int          lat_ee;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(int idx);
    int cyc, lat;
    vec_t v;
    v = vecs[idx];
`ifdef MULT_EARLY_EXIT_EN
    lat = v.lat_ee;
`else
    lat = v.lat_def;
`endif
    @(negedge clk);
    mif.a = v.a; mif.b = v.b; mif.is_signed = v.s; mif.start = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    mif.a = $urandom; mif.b = $urandom; mif.is_signed = 1'($urandom);
    wait_done($sformatf("vec%0d", idx), cyc);
    check32($sformatf("vec%0d_hi", idx), mif.hi, v.hi);
    check32($sformatf("vec%0d_lo", idx), mif.lo, v.lo);
    check_int($sformatf("vec%0d_latency", idx), cyc, lat);
  endtask

  initial begin
    int cyc;
    tests = 0; fails = 0; cmp_en = 0;
    mif.start = 0; mif.is_signed = 0; mif.a = '0; mif.b = '0;
    //           a             b             s   hi            lo           def ee
    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 32, 32};
    vecs[1] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 34,  6};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 32, 32};
    vecs[3] = '{32'h00000000, 32'hFFFFFFF9, 1'b1, 32'h00000000, 32'h00000000, 34,  6};
    vecs[4] = '{32'h00000007, 32'h00000003, 1'b0, 32'h00000000, 32'h00000015, 32,  3};
    vecs[5] = '{32'h00000005, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32,  1};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, 32,  2};
    vecs[7] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000, 34, 34};
    vecs[8] = '{32'h00000064, 32'hFFFFFF9C, 1'b1, 32'hFFFFFFFF, 32'hFFFFD8F0, 34, 10};

    rst_n = 1'b0;
    #23;
    check32("reset_busy", 32'(mif.busy), 32'd0);
    check32("reset_done", 32'(mif.done), 32'd0);
    check32("reset_hi", mif.hi, 32'd0);
    check32("reset_lo", mif.lo, 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    cmp_en = 1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // start held high with operands changing during CALC, then back-to-back.
    @(negedge clk);
    mif.a = 32'd7; mif.b = 32'd3; mif.is_signed = 1'b0; mif.start = 1'b1;
    @(posedge clk); #1;
    mif.a = 32'd2; mif.b = 32'd2;
    wait_done("hold_first", cyc);
    check32("hold_first_lo", mif.lo, 32'd21);
    check32("hold_first_hi", mif.hi, 32'd0);
    @(posedge clk); #1;
    mif.start = 1'b0;
    check32("done_cycle_restart_busy", 32'(mif.busy), 32'd1);
    wait_done("hold_second", cyc);
    check32("hold_second_lo", mif.lo, 32'd4);
`ifdef MULT_EARLY_EXIT_EN
    check_int("hold_second_latency", cyc, 3);
`else
    check_int("hold_second_latency", cyc, 32);
`endif

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    mif.a = 32'hFFFFFFFD; mif.b = 32'h00000005; mif.is_signed = 1'b1; mif.start = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check32("midreset_busy", 32'(mif.busy), 32'd0);
    check32("midreset_hi", mif.hi, 32'd0);
    check32("midreset_lo", mif.lo, 32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    run_vec(4);
    run_vec(1);

    repeat (3) @(negedge clk);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
